inst_encoder: RTL

//  Inverse of the decode stage: packs RV32I fields (opcode/rd/rs1/rs2/func3/func7/imm) into
//  32-bit instruction words and streams them into instruction memory as a program loader.

---
 rtl/inst_encoder.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/inst_encoder.sv
// inst_encoder: RV32I field packer and instruction-memory program loader.
// Accepts decoded instruction fields over a valid/ready beat interface, packs
// each beat into a 32-bit RV32I word and streams the words to the imem write
// port through a one-entry stalling output register.
// Optional feature macro: INST_ENC_RANGE_CHECK_EN enables the immediate-fit
// check (error code 11); without it the encoding is identical and code 11 is
// never raised.

module inst_encoder #(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [6:0]        opcode,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [2:0]        func3,
    input  logic [6:0]        func7,
    input  logic [31:0]       imm,
    input  logic              last,
    input  logic              mem_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_inst,
    output logic [ADDR_W:0]   count,
    output logic              done,
    output logic [1:0]        err_code
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    localparam logic [1:0] ERR_OK     = 2'b00;
    localparam logic [1:0] ERR_OPCODE = 2'b01;
    localparam logic [1:0] ERR_OVF    = 2'b10;
    localparam logic [1:0] ERR_RANGE  = 2'b11;

    localparam logic [ADDR_W-1:0] ADDR_BASE = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

    state_t              state_q, state_d;
    logic                wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [31:0]         wr_inst_q, wr_inst_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic [1:0]          err_q, err_d;

    logic [31:0]         enc_word;
    logic                op_bad;
    logic                imm_bad;
    logic                wr_fire;
    logic                accept;
    logic                at_end;

    // Pack the current beat's fields into an RV32I word according to its opcode.
    always_comb begin
        enc_word = NOP_WORD;
        op_bad   = 1'b0;
        case (opcode)
            OP_R: begin
                enc_word = {func7, rs2, rs1, func3, rd, opcode};
            end
            OP_IMM: begin
                // Shift-immediates carry funct7 in the upper immediate bits.
                if (func3 == 3'b001 || func3 == 3'b101) begin
                    enc_word = {func7, imm[4:0], rs1, func3, rd, opcode};
                end else begin
                    enc_word = {imm[11:0], rs1, func3, rd, opcode};
                end
            end
            OP_LOAD, OP_JALR, OP_SYSTEM: begin
                enc_word = {imm[11:0], rs1, func3, rd, opcode};
            end
            OP_STORE: begin
                enc_word = {imm[11:5], rs2, rs1, func3, imm[4:0], opcode};
            end
            OP_BRANCH: begin
                enc_word = {imm[12], imm[10:5], rs2, rs1, func3, imm[4:1], imm[11], opcode};
            end
            OP_LUI, OP_AUIPC: begin
                enc_word = {imm[31:12], rd, opcode};
            end
            OP_JAL: begin
                enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
            end
            default: begin
                op_bad = 1'b1;
            end
        endcase
    end

`ifdef INST_ENC_RANGE_CHECK_EN
    logic fit12;
    logic fit13;
    logic fit21;

    // Flag immediates whose value cannot be represented by their format.
    always_comb begin
        fit12   = (imm[31:11] == '0) || (imm[31:11] == '1);
        fit13   = (imm[31:12] == '0) || (imm[31:12] == '1);
        fit21   = (imm[31:20] == '0) || (imm[31:20] == '1);
        imm_bad = 1'b0;
        case (opcode)
            OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM, OP_STORE: imm_bad = !fit12;
            OP_BRANCH:                                     imm_bad = !fit13 || imm[0];
            OP_JAL:                                        imm_bad = !fit21 || imm[0];
            OP_LUI, OP_AUIPC:                              imm_bad = (imm[11:0] != '0);
            default:                                       imm_bad = 1'b0;
        endcase
    end
`else
    // Immediate range checking is compiled out.
    always_comb begin
        imm_bad = 1'b0;
    end
`endif

    assign in_ready = (state_q == S_LOAD) && (!wr_en_q || mem_ready);
    assign wr_fire  = wr_en_q && mem_ready;
    assign accept   = in_valid && in_ready;

    // Next-state logic: load FSM, output register, address/count and sticky error.
    always_comb begin
        state_d   = state_q;
        wr_en_d   = wr_en_q;
        wr_addr_d = wr_addr_q;
        wr_inst_d = wr_inst_q;
        count_d   = count_q;
        err_d     = err_q;

        // A completed write advances the address first, so a beat accepted in
        // the same cycle lands on the following address; the address saturates
        // at the top of memory instead of wrapping.
        if (wr_fire) begin
            wr_en_d = 1'b0;
            count_d = count_q + (ADDR_W + 1)'(1);
            if (wr_addr_q != ADDR_LAST) begin
                wr_addr_d = wr_addr_q + ADDR_W'(1);
            end
        end
        at_end = (wr_addr_d == ADDR_LAST);

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d   = S_LOAD;
                    wr_en_d   = 1'b0;
                    wr_addr_d = ADDR_BASE;
                    count_d   = '0;
                    err_d     = ERR_OK;
                end
            end
            S_LOAD: begin
                if (accept) begin
                    wr_en_d   = 1'b1;
                    wr_inst_d = enc_word;
                    if (err_q == ERR_OK) begin
                        if (op_bad) begin
                            err_d = ERR_OPCODE;
                        end else if (at_end && !last) begin
                            err_d = ERR_OVF;
                        end else if (imm_bad) begin
                            err_d = ERR_RANGE;
                        end
                    end
                    if (last || at_end) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (wr_fire) begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            wr_en_q   <= 1'b0;
            wr_addr_q <= ADDR_BASE;
            wr_inst_q <= '0;
            count_q   <= '0;
            err_q     <= ERR_OK;
        end else begin
            state_q   <= state_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_inst_q <= wr_inst_d;
            count_q   <= count_d;
            err_q     <= err_d;
        end
    end

    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_inst  = wr_inst_q;
    assign count    = count_q;
    assign done     = (state_q == S_DONE);
    assign err_code = err_q;

endmodule
